fetch_unit: RTL

Instruction fetch front-end for the RISC-V core: it owns the fetch PC, issues word reads to instruction memory, and buffers returned instructions with their PCs in a small FIFO. It sits directly upstream of the datapath's decode step. The datapath consumes `{instr, instr_pc}` through a valid/ready handshake, and on a taken branch or jump it redirects fetch with `redir`/`redir_pc`. Memory latency is variable, with one request outstanding at a time.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: FSM states, FIFO entry bundle, reset PC.
// FS_HALT exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    FS_HALT
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry instruction FIFO with wrap-around pointers.
// Flush takes priority over push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: owns fetch PC, one outstanding imem read, buffers instrs.
// Define FETCH_MISALIGN_CHECK_EN for the misalign flag and FS_HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redir,
  input  logic [31:0] redir_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc, pc_d, req_pc;
  logic          drop, drop_d, req_q, req_d;
  logic          granted, resp, push, pop;
  logic          bad_redir, room;
  logic [CW-1:0] count;
  fetch_entry_t  head, din;

  assign granted = req_q && imem_gnt;
  assign resp    = (state_q == FS_WAIT) && imem_rvalid;
  assign room    = count < CW'(DEPTH);
  assign pop     = instr_valid && instr_ready;
  assign push    = resp && !drop && !redir;
  assign din     = '{instr: imem_rdata, pc: req_pc};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_redir = redir && (redir_pc[1:0] != 2'b00);
`else
  logic unused_lo;
  assign bad_redir = 1'b0;
  assign unused_lo = ^redir_pc[1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE: if (granted) state_d = FS_WAIT;
      FS_WAIT: if (imem_rvalid) state_d = FS_IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
      // a stale response may still be owed when leaving halt
      FS_HALT:
        if (redir && !bad_redir)
          state_d = (drop && !imem_rvalid) ? FS_WAIT : FS_IDLE;
`endif
      default: state_d = FS_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (bad_redir) state_d = FS_HALT;
`endif
  end

  always_comb begin
    pc_d = fetch_pc;
    if (granted) pc_d = fetch_pc + 32'd4;
    if (redir)   pc_d = {redir_pc[31:2], 2'b00};

    drop_d = drop;
    if (imem_rvalid && state_q != FS_IDLE) drop_d = 1'b0;
    if (redir && (granted || (state_q == FS_WAIT && !imem_rvalid)))
      drop_d = 1'b1;

    // a dropped response reissues at once; a normal one leaves a gap
    if (redir)                   req_d = state_d == FS_IDLE;
    else if (resp)               req_d = drop;
    else if (state_q == FS_IDLE) req_d = !granted && (req_q || room || pop);
    else                         req_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      fetch_pc <= pc_d;
      drop     <= drop_d;
      req_q    <= req_d;
      if (granted) req_pc <= fetch_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        misalign <= 1'b0;
    else if (redir) misalign <= bad_redir;
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = count != '0;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule
